key_debounce: RTL
=================

# key_debounce

Front-end conditioning stage for the `midi` block: takes the ten raw, bouncing, asynchronous key switches and synchronises and debounces them. Presents a clean `key[9:0]` vector plus a one-cycle `ena` strobe whenever that vector changes. Its `key` and `ena` outputs wire directly to the `key` and `ena` inputs of `midi`. A single shared prescaler paces all ten per-key debounce counters.

## Interface

Parameters:
- `TICK_DIV`, 100000, clock cycles per debounce sample tick (1 ms at 100 MHz); legal ≥ 2.
- `STABLE_TICKS`, 10, consecutive disagreeing ticks required to accept a new key level; legal ≥ 1.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; one clock; no other clock domains.
- `key_raw`  in  10  raw switch levels, asynchronous to `clk`; bit n = key n.
- `key`  out  10  debounced key state, 1 = pressed.
- `ena`  out  1  one-cycle strobe: `key` changed on this cycle's preceding edge.
- `changed`  out  10  bits of `key` that changed; valid while `ena`=1, zero otherwise.

## Operation

- **Synchroniser.** Each `key_raw` bit passes a 2-FF synchroniser; the second stage is `s[n]`.
- **Prescaler.** Counts 0..`TICK_DIV`-1 and wraps. Internal `tick` is high for the one cycle where count = `TICK_DIV`-1.
- **Per-key state.** Each key n holds a debounced bit `key[n]` and a counter `cnt[n]`, width clog2(`STABLE_TICKS`+1).
- **On a tick cycle, per key:**
  - `s[n]` == `key[n]`: `cnt[n]` ← 0.
  - `s[n]` != `key[n]` and `cnt[n]` < `STABLE_TICKS`-1: `cnt[n]` increments.
  - `s[n]` != `key[n]` and `cnt[n]` == `STABLE_TICKS`-1: `key[n]` ← `s[n]`, `cnt[n]` ← 0, `changed[n]` ← 1.
- **Non-tick cycles.** `cnt`/`key` hold. Bounces between ticks are invisible; a bounce sampled on any tick restarts the count.
- **Strobe.** `ena` ← OR of the per-key update conditions; `changed` ← the update mask. Both are registered with `key`, so all three update on the same edge.
- **Multiple keys.** Keys qualifying on the same tick produce one `ena` pulse, with several bits set in `changed`.
- **Ordering.** Consecutive `ena` pulses are at least `TICK_DIV` cycles apart.
- **Reset values.** `key`=0, `ena`=0, `changed`=0, all `cnt`=0, prescaler=0, synchroniser FFs at the released level.
- **Reset mid-operation.** Discards partial counts. After release, a held key is re-accepted after the full `STABLE_TICKS` interval and produces an `ena` pulse.

## Timing

- **Synchroniser latency.** A `key_raw` edge reaches `s[n]` 2–3 cycles later, depending on metastability resolution.
- **Acceptance.** Requires `STABLE_TICKS` consecutive tick samples that disagree with `key[n]`.
  - Latency from `s[n]` change to `key[n]` update ranges from (`STABLE_TICKS`-1)·`TICK_DIV`+1 to `STABLE_TICKS`·`TICK_DIV` cycles.
  - It is measured from the `s[n]` edge to the edge ending the qualifying tick cycle.
- **`ena` width.** Exactly 1 cycle. `changed` returns to 0 on the next edge.
- **No back-pressure.** `midi` must sample `ena`/`key` every cycle.
- **Prescaler wrap.** Free-running; unaffected by key activity.

## Configuration

- `KEY_DEBOUNCE_ACTIVE_LOW_EN` defined:
  - `key_raw` is active-low; each bit is inverted after the synchroniser.
  - Synchroniser FFs reset to 1.
- `KEY_DEBOUNCE_ACTIVE_LOW_EN` undefined:
  - `key_raw` is active-high with no inversion.
  - Synchroniser FFs reset to 0.
- In both cases `key`, `ena` and `changed` keep identical semantics, and `key` bit = 1 means pressed.

## Test plan

All scenarios use `TICK_DIV`=4, `STABLE_TICKS`=3, active-high unless stated.

- **Reset.** Assert `rst` with `key_raw`=10'h3FF → `key`=0, `ena`=0, `changed`=0 throughout reset.
- **Clean press.** `key_raw`=10'h001 held → after ≤ 12+3 cycles, `key`=10'h001; one `ena` pulse with `changed`=10'h001; no further pulses while held.
- **Bounce.** Toggle bit 2 every 5 cycles for 40 cycles, then hold 1 → no `ena` during toggling; exactly one `ena` with `changed`=10'h004 after the hold.
- **Simultaneous change.** From `key`=10'h001, set `key_raw`=10'h202 in one cycle → single `ena` with `changed`=10'h203, `key`=10'h202.
- **Reset mid-count.** Press bit 5, assert `rst` after 2 ticks, release `rst` with bit 5 still held → `key`=0 until 3 fresh ticks elapse, then `key`=10'h020 with one `ena`.
- **Active-low build.** Compile with `KEY_DEBOUNCE_ACTIVE_LOW_EN` and drive `key_raw`=10'h3FE → `key`=10'h001 and one `ena` pulse; with `key_raw`=10'h3FF idle after reset, no `ena` occurs.

Source files
------------

// File: rtl/key_debounce.sv
// Ten-key synchroniser and debouncer feeding midi: clean key[9:0] plus a one-cycle ena/changed strobe.
// Define KEY_DEBOUNCE_ACTIVE_LOW_EN for active-low switches (inverted after the synchroniser).
module key_debounce #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    output logic [9:0] key,
    output logic       ena,
    output logic [9:0] changed
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    localparam logic [9:0] SYNC_RST = 10'h3FF;
`else
    localparam logic [9:0] SYNC_RST = 10'h000;
`endif

    logic [9:0]       sync_p0;
    logic [9:0]       sync_p1;
    logic [9:0]       s;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt     [10];
    logic [CNT_W-1:0] cnt_nxt [10];
    logic [9:0]       upd;

    // Stage p0/p1: two-flop synchroniser, reset to the released switch level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= SYNC_RST;
            sync_p1 <= SYNC_RST;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    assign s = ~sync_p1;
`else
    assign s = sync_p1;
`endif

    // Free-running shared prescaler; tick marks the last count of each period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_comb begin
        upd = '0;
        for (int n = 0; n < 10; n++) begin
            cnt_nxt[n] = cnt[n];
            if (tick) begin
                if (s[n] == key[n]) begin
                    cnt_nxt[n] = '0;
                end else if (cnt[n] == CNT_LAST) begin
                    cnt_nxt[n] = '0;
                    upd[n]     = 1'b1;
                end else begin
                    cnt_nxt[n] = cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced state and strobe update together; an accepted key always flips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key     <= '0;
            ena     <= 1'b0;
            changed <= '0;
            for (int n = 0; n < 10; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            key     <= key ^ upd;
            ena     <= |upd;
            changed <= upd;
            for (int n = 0; n < 10; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
        end
    end

endmodule
